prewish5k_button_mask_latch: RTL and testbench
==============================================

// Module: prewish5k_button_mask_latch
// PURPOSE
//  Upstream front end of the prewish5k blinky chain: synchronizes and debounces the active-low
//  pushbutton. On each accepted press it captures the active-low 8-bit DIP mask, inverts it, and
//  presents it to the downstream mask consumer as an 8-bit data word with a STB pulse.
//  A release lockout suppresses re-triggers from button bounce and button mashing.
// PARAMETERS
//  DEBOUNCE_BITS  20  press/release must be stable for 2**DEBOUNCE_BITS clocks to be accepted
//  LOCKOUT_BITS   22  ignore interval after an accepted release: 2**LOCKOUT_BITS clocks
// PORTS
//  i_clk       in   1  system clock (global buffer)
//  i_rst_n     in   1  asynchronous reset, active-low
//  i_button    in   1  raw pushbutton, active-low, asynchronous
//  i_dip       in   8  raw DIP switches, active-low, quasi-static
//  o_stb       out  1  STB_O: new mask valid
//  o_data      out  8  DAT_O: captured mask, active-high (= ~i_dip at capture)
//  o_busy      out  1  high in any state other than IDLE
//  i_ack       in   1  ACK_I (present only with PREWISH5K_MASK_ACK_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): o_stb=0, o_data=8'h00, o_busy=0.
//    Sync flops reset to 1 (button released; DIP all-off). FSM=IDLE, counter=0.
//  - i_button and i_dip each pass through a 2-flop synchronizer (btn_s, dip_s). The FSM sees only
//    the synchronized signals.
//  - FSM states: IDLE, DEB_PRESS, STROBE, WAIT_REL, LOCKOUT.
//    IDLE: btn_s==0 -> DEB_PRESS, cnt<=0.
//    DEB_PRESS: btn_s==1 -> IDLE (bounce rejected). Else if cnt==2**D-1 -> STROBE and
//      o_data<=~dip_s. Else cnt++.
//    STROBE: o_stb=1 for exactly one clock -> WAIT_REL, cnt<=0.
//    WAIT_REL: btn_s==0 -> cnt<=0. btn_s==1 && cnt==2**D-1 -> LOCKOUT, cnt<=0. Else cnt++.
//    LOCKOUT: counts 2**LOCKOUT_BITS clocks; button ignored. At terminal count:
//      btn_s==0 -> WAIT_REL (held or re-pressed; a fresh release is required).
//      btn_s==1 -> IDLE.
//  - Latency: the first clock edge that samples i_button low is edge 0. If the button stays low,
//    o_stb is high in the cycle after edge 2**D+2.
//  - o_stb is registered (o_stb = state==STROBE). o_data is stable from the STROBE cycle until
//    the next capture.
//  - Counter width = max(D, L). It never wraps: it is cleared on every state entry.
//  - DIP changes after capture do not affect o_data until the next accepted press.
//  - Reset mid-operation: immediate return to the reset values above. No o_stb glitch.
// CONFIGURATION
//  PREWISH5K_MASK_ACK_EN defined:
//    - i_ack port exists. STROBE holds o_stb=1 until i_ack==1 is sampled, then -> WAIT_REL.
//    - i_ack in the same cycle STROBE is entered completes the transfer in 1 cycle.
//    - Button activity while in STROBE is ignored.
//  Undefined:
//    - No i_ack port. One-cycle o_stb pulse; the consumer must accept every pulse.
// STRUCTURE
//  Shared package prewish5k_pkg:
//    - FSM state localparams (3-bit encoding).
//    - MASK_W=8.
//    - Default DEBOUNCE_BITS and LOCKOUT_BITS.
//  Sub-module prewish5k_sync2 (param WIDTH, reset value RST_VAL): 2-flop synchronizer.
//  Instance use: once for the button (WIDTH=1), once for the DIP (WIDTH=8).
// TESTING (DEBOUNCE_BITS=3, LOCKOUT_BITS=5)
//  1. i_button=0 from edge 0, i_dip=8'b01011111 -> o_stb=1 for 1 cycle after edge 10,
//     o_data=8'hA0, o_busy=1.
//  2. i_button low for 5 clocks then high -> no o_stb; FSM returns to IDLE, o_busy=0.
//  3. Accept a press, release, then re-press 10 clocks after release (inside lockout) -> no
//     second o_stb. A re-press after lockout ends, with i_dip=8'b00110011 -> o_stb, o_data=8'hCC.
//  4. Button held low throughout -> exactly one o_stb; next o_stb only after release + lockout +
//     a new press.
//  5. Assert i_rst_n=0 in DEB_PRESS and again in STROBE -> o_stb=0, o_data=8'h00 immediately;
//     after release, normal press gives o_stb.
//  6. ACK_EN build: i_ack held 0 for 4 cycles -> o_stb stays 1, o_data constant; i_ack=1 ->
//     o_stb falls next cycle.

Source files
------------

// File: rtl/prewish5k_pkg.sv
// rtl/prewish5k_pkg.sv - shared FSM encoding, mask width and default timing for the prewish5k front end
package prewish5k_pkg;

  localparam int MASK_W            = 8;
  localparam int DEF_DEBOUNCE_BITS = 20;
  localparam int DEF_LOCKOUT_BITS  = 22;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_DEB_PRESS = 3'd1;
  localparam state_t ST_STROBE    = 3'd2;
  localparam state_t ST_WAIT_REL  = 3'd3;
  localparam state_t ST_LOCKOUT   = 3'd4;

endpackage

// File: rtl/prewish5k_sync2.sv
// rtl/prewish5k_sync2.sv - two-flop synchronizer with configurable width and reset value
module prewish5k_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/prewish5k_button_mask_latch.sv
// rtl/prewish5k_button_mask_latch.sv - debounced button captures inverted DIP mask with strobe
// Optional consumer handshake: define PREWISH5K_MASK_ACK_EN to add i_ack and hold o_stb until acked.
module prewish5k_button_mask_latch
  import prewish5k_pkg::*;
#(
  parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
  parameter int LOCKOUT_BITS  = DEF_LOCKOUT_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_button,
  input  logic [MASK_W-1:0] i_dip,
  output logic              o_stb,
  output logic [MASK_W-1:0] o_data,
`ifdef PREWISH5K_MASK_ACK_EN
  output logic              o_busy,
  input  logic              i_ack
`else
  output logic              o_busy
`endif
);

  localparam int CNT_W = (DEBOUNCE_BITS > LOCKOUT_BITS) ? DEBOUNCE_BITS : LOCKOUT_BITS;
  localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'((64'd1 << DEBOUNCE_BITS) - 64'd1);
  localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'((64'd1 << LOCKOUT_BITS) - 64'd1);

  logic              btn_s;
  logic [MASK_W-1:0] dip_s;
  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              capture;
  logic              stb_q;

  prewish5k_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_btn (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_button),
    .q     (btn_s)
  );

  prewish5k_sync2 #(.WIDTH(MASK_W), .RST_VAL({MASK_W{1'b1}})) u_sync_dip (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_dip),
    .q     (dip_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Every state change clears the counter, so it only ever counts the dwell in one state.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!btn_s) begin
          state_next = ST_DEB_PRESS;
          cnt_clr    = 1'b1;
        end
      end
      ST_DEB_PRESS: begin
        if (btn_s) begin
          state_next = ST_IDLE;
          cnt_clr    = 1'b1;
        end else if (cnt == DEB_TERM) begin
          state_next = ST_STROBE;
          cnt_clr    = 1'b1;
          capture    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_STROBE: begin
`ifdef PREWISH5K_MASK_ACK_EN
        if (i_ack) begin
          state_next = ST_WAIT_REL;
          cnt_clr    = 1'b1;
        end
`else
        state_next = ST_WAIT_REL;
        cnt_clr    = 1'b1;
`endif
      end
      ST_WAIT_REL: begin
        if (!btn_s) begin
          cnt_clr = 1'b1;
        end else if (cnt == DEB_TERM) begin
          state_next = ST_LOCKOUT;
          cnt_clr    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        // A button still low at the end means held or re-pressed: demand a fresh release.
        if (cnt == LOCK_TERM) begin
          state_next = btn_s ? ST_IDLE : ST_WAIT_REL;
          cnt_clr    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      o_data <= '0;
      stb_q  <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (capture)      o_data <= ~dip_s;
      stb_q <= (state_next == ST_STROBE);
    end
  end

  always_comb begin
    o_stb  = stb_q;
    o_busy = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_prewish5k_button_mask_latch.sv
// tb/tb_prewish5k_button_mask_latch.sv - scoreboard bench with segment-level press/release model
module tb_prewish5k_button_mask_latch;

  localparam int D    = 3;
  localparam int L    = 5;
  localparam int DEB  = 1 << D;
  localparam int LOCK = 1 << L;
  localparam int SETTLE = DEB + LOCK + 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b1;
  logic [7:0] dip = 8'hFF;
  logic       stb;
  logic [7:0] data;
  logic       busy;
`ifdef PREWISH5K_MASK_ACK_EN
  logic       ack = 1'b1;
`endif

  always #5 clk = ~clk;

  prewish5k_button_mask_latch #(.DEBOUNCE_BITS(D), .LOCKOUT_BITS(L)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_button (button),
    .i_dip    (dip),
    .o_stb    (stb),
    .o_data   (data),
`ifdef PREWISH5K_MASK_ACK_EN
    .o_busy   (busy),
    .i_ack    (ack)
`else
    .o_busy   (busy)
`endif
  );

  int         checks = 0;
  int         passes = 0;
  int         pushes = 0;
  int         stb_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_data = 8'h00;
  logic       prev_stb = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // An accepted press always latches the inverse of the DIP setting it was made with.
  task automatic expect_capture(input logic [7:0] dv);
    exp_q.push_back(~dv);
    model_data = ~dv;
    pushes++;
  endtask

  task automatic hold(input logic level, input int n);
    button = level;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && stb && !prev_stb) begin
      stb_seen++;
      if (exp_q.size() == 0) check("unexpected_stb", 32'd1, 32'd0);
      else check("stb_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
    end
`ifndef PREWISH5K_MASK_ACK_EN
    if (rst_n && stb && prev_stb) check("stb_width", 32'd2, 32'd1);
`endif
    prev_stb = stb;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int first_k;
    int waited;
    logic [7:0] r;
    logic [7:0] d0;

    repeat (3) @(negedge clk);
    check("reset_stb", {31'd0, stb}, 32'd0);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Latency: button low just before edge 0, strobe visible after edge 2**D+2.
    dip = 8'b01011111;
    expect_capture(dip);
    button = 1'b0;
    first_k = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (stb && first_k < 0) first_k = k;
      if (k == 10) check("busy_in_strobe", {31'd0, busy}, 32'd1);
      if (k == 11) check("stb_one_cycle", {31'd0, stb}, 32'd0);
    end
    check("latency_edge", first_k, 32'd10);
    @(negedge clk);
    hold(1'b0, 4);
    hold(1'b1, SETTLE);
    check("data_hold_a0", {24'd0, data}, {24'd0, model_data});

    // Short press is bounce.
    dip = 8'($urandom);
    hold(1'b0, 5);
    hold(1'b1, 6);
    check("bounce_idle", {31'd0, busy}, 32'd0);
    check("bounce_data", {24'd0, data}, {24'd0, model_data});

    // Re-press inside lockout is ignored; re-press after lockout captures 0xCC.
    r = 8'($urandom); dip = r;
    expect_capture(r);
    hold(1'b0, 14); hold(1'b1, 10); hold(1'b0, 12); hold(1'b1, SETTLE);
    dip = 8'b00110011;
    expect_capture(dip);
    hold(1'b0, 14); hold(1'b1, SETTLE);
    check("data_cc", {24'd0, data}, 32'hCC);

    // Held button: one capture; later DIP changes do not reach o_data.
    r = 8'($urandom); dip = r;
    expect_capture(r);
    hold(1'b0, 20);
    dip = ~r;
    hold(1'b0, 40);
    check("held_data", {24'd0, data}, {24'd0, model_data});
    hold(1'b1, SETTLE);

    // Reset while debouncing.
    hold(1'b0, 5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_deb_stb", {31'd0, stb}, 32'd0);
    check("rst_deb_data", {24'd0, data}, 32'd0);
    check("rst_deb_busy", {31'd0, busy}, 32'd0);
    model_data = 8'h00;
    button = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset during the strobe cycle.
    r = 8'($urandom); dip = r;
    expect_capture(r);
    button = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!stb && waited < 30);
    check("strobe_seen_before_rst", {31'd0, stb}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_stb_stb", {31'd0, stb}, 32'd0);
    check("rst_stb_data", {24'd0, data}, 32'd0);
    model_data = 8'h00;
    button = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    r = 8'($urandom); dip = r;
    expect_capture(r);
    hold(1'b0, 14); hold(1'b1, SETTLE);
    check("after_rst_data", {24'd0, data}, {24'd0, model_data});

    // Randomized segments: bounce, clean press, lockout re-press, held through lockout end.
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom); dip = r;
      case ($urandom_range(0, 3))
        0: begin
          hold(1'b0, $urandom_range(1, DEB - 2));
          hold(1'b1, $urandom_range(3, 6));
        end
        1: begin
          expect_capture(r);
          hold(1'b0, $urandom_range(DEB + 4, DEB + 12));
          hold(1'b1, SETTLE);
        end
        2: begin
          expect_capture(r);
          hold(1'b0, 14); hold(1'b1, 10);
          hold(1'b0, $urandom_range(3, 12));
          hold(1'b1, SETTLE);
        end
        default: begin
          expect_capture(r);
          hold(1'b0, 14); hold(1'b1, 10);
          hold(1'b0, 50);
          hold(1'b1, SETTLE);
        end
      endcase
      check("seg_data", {24'd0, data}, {24'd0, model_data});
    end

`ifdef PREWISH5K_MASK_ACK_EN
    ack = 1'b0;
    r = 8'($urandom); dip = r;
    expect_capture(r);
    button = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!stb && waited < 30);
    d0 = data;
    check("ack_strobe_seen", {31'd0, stb}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ack_hold_stb", {31'd0, stb}, 32'd1);
      check("ack_hold_data", {24'd0, data}, {24'd0, d0});
    end
    ack = 1'b1;
    @(negedge clk);
    check("ack_release_stb", {31'd0, stb}, 32'd0);
    hold(1'b1, SETTLE);
`else
    d0 = data;
    check("final_data", {24'd0, d0}, {24'd0, model_data});
`endif

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    check("stb_count", stb_seen, pushes);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
